// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 memory responder.
//   - rc4_mode_e  : request encoding driven by the RC4 core on rc4_mode_i
//   - rsp_state_e : responder FSM states
//   - AddrWidth   : SRAM word-address width
//   - word_addr() : base + pointer, modulo 2^AddrWidth
package rc4_pkg;

    localparam int unsigned AddrWidth  = 18;
    localparam int unsigned DataWidth  = 32;
    localparam int unsigned TimerWidth = 8;

    typedef enum logic [1:0] {
        ModeIdle    = 2'b00,
        ModeRead    = 2'b01,
        ModeWrite   = 2'b10,
        ModeIllegal = 2'b11
    } rc4_mode_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdReq   = 3'd1,
        StWrReq   = 3'd2,
        StResp    = 3'd3,
        StRelease = 3'd4
    } rsp_state_e;

    // Address arithmetic truncates to AddrWidth, so images wrap around the SRAM.
    function automatic logic [AddrWidth-1:0] word_addr(input logic [AddrWidth-1:0] base,
                                                       input logic [AddrWidth-1:0] ptr);
        return base + ptr;
    endfunction

endpackage

// File: rtl/rc4_ack_timer.sv
// rc4_ack_timer: saturating clear/enable counter with terminal-count flag.
// Ports:
//   clk      - clock
//   rst_i    - asynchronous active-high reset
//   clr_i    - synchronous clear (dominates enable)
//   en_i     - count enable
//   limit_i  - terminal count value
//   tc_o     - high while the count equals limit_i
module rc4_ack_timer
    import rc4_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [TimerWidth-1:0] limit_i,
    output logic                  tc_o
);

    logic [TimerWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {TimerWidth{1'b1}})) begin
            // Saturate rather than wrap so the flag cannot be skipped.
            count_d = count_q + TimerWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/rc4_mem_responder.sv
// rc4_mem_responder: services word read/write requests from the RC4 core against an
// external SRAM. Reads walk the encrypted source image, writes walk the decrypted
// destination image, each with its own auto-incrementing word pointer.
// Ports:
//   clk, rst_i               - clock, asynchronous active-high reset
//   rc4_mode_i               - 00 idle, 01 read, 10 write, 11 illegal
//   rc4_clear_i              - zero both pointers and the sticky error
//   rc4_wdata_i              - word to write (sampled when a write is accepted)
//   rc4_rdata_o              - last word successfully read
//   rc4_dfb_o                - one-cycle done pulse per request
//   sram_addr_o/sram_wdata_o - SRAM word address / write data
//   sram_ren_o/sram_wen_o    - SRAM strobes, held until sram_ack_i
//   sram_rdata_i/sram_ack_i  - SRAM read data / completion
//   err_o                    - sticky error: illegal mode or ack timeout
module rc4_mem_responder
    import rc4_pkg::*;
#(
    parameter logic [AddrWidth-1:0]  SRC_BASE    = 18'h00000,
    parameter logic [AddrWidth-1:0]  DST_BASE    = 18'h20000,
    parameter logic [TimerWidth-1:0] ACK_TIMEOUT = 8'd255
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [1:0]           rc4_mode_i,
    input  logic                 rc4_clear_i,
    input  logic [DataWidth-1:0] rc4_wdata_i,
    output logic [DataWidth-1:0] rc4_rdata_o,
    output logic                 rc4_dfb_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic                 sram_ren_o,
    output logic                 sram_wen_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    input  logic                 sram_ack_i,
    output logic                 err_o
);

    rsp_state_e           state_q;
    rc4_mode_e            mode;
    logic [AddrWidth-1:0] rd_ptr_q, wr_ptr_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q, rdata_q;
    logic                 ren_q, wen_q, dfb_q, err_q;
    logic                 in_req, timer_tc;

    assign mode   = rc4_mode_e'(rc4_mode_i);
    assign in_req = (state_q == StRdReq) || (state_q == StWrReq);

    // Counter is held at zero outside the request states, so it restarts on every entry.
    rc4_ack_timer u_ack_timer (
        .clk     (clk),
        .rst_i   (rst_i),
        .clr_i   (!in_req),
        .en_i    (in_req && !sram_ack_i),
        .limit_i (ACK_TIMEOUT),
        .tc_o    (timer_tc)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            dfb_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dfb_q <= 1'b0;
            // A new error raised in this same cycle still sets the flag below.
            if (rc4_clear_i) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    unique case (mode)
                        ModeRead: begin
                            ren_q   <= 1'b1;
                            addr_q  <= word_addr(SRC_BASE, rd_ptr_q);
                            state_q <= StRdReq;
                        end
                        ModeWrite: begin
                            wen_q   <= 1'b1;
                            addr_q  <= word_addr(DST_BASE, wr_ptr_q);
                            wdata_q <= rc4_wdata_i;
                            state_q <= StWrReq;
                        end
                        ModeIllegal: begin
                            err_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                StRdReq: begin
                    if (sram_ack_i) begin
                        rdata_q  <= sram_rdata_i;
                        rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
                        ren_q    <= 1'b0;
                        dfb_q    <= 1'b1;
                        state_q  <= StResp;
                    end else if (timer_tc) begin
                        // Give up: report completion so the core never stalls.
                        err_q   <= 1'b1;
                        ren_q   <= 1'b0;
                        dfb_q   <= 1'b1;
                        state_q <= StResp;
                    end
                end
                StWrReq: begin
                    if (sram_ack_i) begin
                        wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
                        wen_q    <= 1'b0;
                        dfb_q    <= 1'b1;
                        state_q  <= StResp;
                    end else if (timer_tc) begin
                        err_q   <= 1'b1;
                        wen_q   <= 1'b0;
                        dfb_q   <= 1'b1;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    // A held request must drop before another can be accepted.
                    if (mode == ModeIdle) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase

            // Placed last so a clear overrides a same-cycle increment.
            if (rc4_clear_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end
        end
    end

    assign rc4_rdata_o  = rdata_q;
    assign rc4_dfb_o    = dfb_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign sram_ren_o   = ren_q;
    assign sram_wen_o   = wen_q;
    assign err_o        = err_q;

endmodule

// File: doc/rc4_mem_responder.md
RC4_MEM_RESPONDER -- requirements
Module: rc4_mem_responder

Interface
REQ-001 SHALL have parameter SRC_BASE, default 18'h00000, word address of encrypted source image.
REQ-002 SHALL have parameter DST_BASE, default 18'h20000, word address of decrypted destination image.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8'd255, maximum cycles waiting for sram_ack_i.
REQ-004 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 Ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-006 Ports: rc4_mode_i  in  2  request from RC4 core: 00 idle, 01 read word, 10 write word, 11 illegal.
REQ-007 Ports: rc4_clear_i  in  1  clear read and write word pointers (image restart).
REQ-008 Ports: rc4_wdata_i  in  32  decrypted word (4 pixels) to write, valid while rc4_mode_i=10.
REQ-009 Ports: rc4_rdata_o  out  32  last word read from SRAM.
REQ-010 Ports: rc4_dfb_o  out  1  one-cycle done-feedback pulse, request completed.
REQ-011 Ports: sram_addr_o  out  18  SRAM word address.
REQ-012 Ports: sram_wdata_o  out  32  SRAM write data.
REQ-013 Ports: sram_ren_o / sram_wen_o  out  1 each  SRAM read/write strobes, held until ack.
REQ-014 Ports: sram_rdata_i  in  32  SRAM read data, valid when sram_ack_i=1.
REQ-015 Ports: sram_ack_i  in  1  SRAM completion.
REQ-016 Ports: err_o  out  1  sticky error: illegal mode or ack timeout.

Function
REQ-017 States: IDLE, RD_REQ, WR_REQ, RESP, RELEASE.
REQ-018 IDLE: mode 01 -> RD_REQ; mode 10 -> WR_REQ (capture rc4_wdata_i); mode 11 -> set err_o, stay IDLE; 00 -> stay.
REQ-019 RD_REQ: sram_ren_o=1, sram_addr_o=SRC_BASE+rd_ptr; on sram_ack_i latch sram_rdata_i into rc4_rdata_o, rd_ptr+1, -> RESP.
REQ-020 WR_REQ: sram_wen_o=1, sram_addr_o=DST_BASE+wr_ptr, sram_wdata_o=captured word; on sram_ack_i wr_ptr+1, -> RESP.
REQ-021 Ack earliest in first REQ cycle; minimum latency mode-seen to rc4_dfb_o = 2 cycles.
REQ-022 Timeout counter clears on REQ entry, increments each REQ cycle without ack; reaching ACK_TIMEOUT: set err_o, pointer unchanged, rc4_rdata_o unchanged, -> RESP (core must never hang).
REQ-023 RESP: rc4_dfb_o=1 for exactly one cycle, -> RELEASE.
REQ-024 RELEASE: wait for rc4_mode_i=00, then -> IDLE; held mode 10 never causes a second write.
REQ-025 Pointers 18-bit, wrap 3FFFF->0; address add is modulo 2^18.
REQ-026 rc4_clear_i zeroes both pointers in any state; if simultaneous with an ack increment, clear wins; in-flight transfer still completes at old address.
REQ-027 rc4_rdata_o holds value until next successful read; pixel n of word is byte [8n+7:8n].
REQ-028 sram_ren_o and sram_wen_o never both 1; both 0 outside REQ states.
REQ-029 err_o cleared only by reset or rc4_clear_i.

Reset
REQ-030 rst_i asserted: state IDLE, pointers 0, timeout counter 0, rc4_rdata_o 0, rc4_dfb_o 0, sram strobes 0, sram_addr_o 0, sram_wdata_o 0, err_o 0, immediately (asynchronous).
REQ-031 Reset mid-transfer abandons the transfer; no dfb pulse after release.

Structure
REQ-032 Shared package rc4_pkg SHALL hold mode encoding enum (IDLE/READ/WRITE/ILLEGAL), responder state enum, word-address width constant 18.
REQ-033 One sub-module rc4_ack_timer (8-bit clear/enable counter with terminal-count flag) SHALL implement the timeout.

Verification
REQ-034 Read: mode 01 one cycle, ack 3 cycles later with 32'hDEADBEEF -> sram_addr_o=SRC_BASE, dfb one pulse, rc4_rdata_o=DEADBEEF, rd_ptr=1.
REQ-035 Write hold: mode 10 held until dfb+1, wdata 32'h01020304, ack immediate -> single wen at DST_BASE, exactly one dfb, wr_ptr=1.
REQ-036 Timeout: read request, ack never -> dfb at cycle ACK_TIMEOUT+2, err_o=1, rd_ptr=0, rc4_rdata_o unchanged.
REQ-037 Wrap/clear: rd_ptr preset 3FFFF via 2^18-1 reads, one more read -> address SRC_BASE+3FFFF then ptr 0; rc4_clear_i with ack same cycle -> ptr 0.
REQ-038 Illegal: mode 11 -> err_o=1, no strobes, no dfb; rst_i pulse mid-WR_REQ -> IDLE, wen 0, no dfb.
